// File: rtl/multi_dataflow_ctrl_fsm_nch.sv
// multi_dataflow_ctrl_fsm_nch: job-control FSM running nb_iter tiles over N sources, M sinks and one engine
module multi_dataflow_ctrl_fsm_nch #(
   parameter int N_IN = 3,
   parameter int N_OUT = 1,
   parameter int CNT_LEN = 1024,
   localparam int CNT_W = $clog2(CNT_LEN) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   trigger_i,
   input  logic [15:0]            nb_iter_i,
   input  logic [CNT_W-1:0]       cnt_limit_i,
   input  logic [N_IN-1:0]        src_ready_i,
   input  logic [N_IN-1:0]        src_done_i,
   input  logic [N_OUT-1:0]       snk_ready_i,
   input  logic [N_OUT-1:0]       snk_done_i,
   input  logic [N_OUT-1:0]       out_hs_i,
   input  logic                   eng_done_i,
   output logic [N_IN-1:0]        src_req_start_o,
   output logic [N_OUT-1:0]       snk_req_start_o,
   output logic                   eng_start_o,
   output logic                   eng_clear_o,
   output logic [N_OUT*CNT_W-1:0] cnt_out_o,
   output logic [15:0]            iter_o,
   output logic                   busy_o,
   output logic                   done_o
);
   typedef enum logic [2:0] {IDLE, START, COMPUTE, WAIT_STRM, UPDATE, FINISHED} state_e;
   state_e state;
   logic [15:0] nb_iter_q;
   logic [CNT_W-1:0] limit_q;
   logic [N_IN-1:0] src_f;
   logic [N_OUT-1:0] snk_f;
   logic eng_f;
   logic at_lim;
   always_comb begin
      at_lim = 1'b1;
      for (int k = 0; k < N_OUT; k++) at_lim = at_lim & (cnt_out_o[k*CNT_W +: CNT_W] == limit_q);
   end
   // Outputs are registered: each reflects the state/decision of the previous cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         nb_iter_q <= '0;
         limit_q <= '0;
         src_f <= '0;
         snk_f <= '0;
         eng_f <= 1'b0;
         cnt_out_o <= '0;
         iter_o <= '0;
         src_req_start_o <= '0;
         snk_req_start_o <= '0;
         eng_start_o <= 1'b0;
         eng_clear_o <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         src_req_start_o <= '0;
         snk_req_start_o <= '0;
         eng_start_o <= 1'b0;
         eng_clear_o <= clear_i;
         busy_o <= !clear_i && state != IDLE;
         done_o <= !clear_i && state == FINISHED;
         if (clear_i) begin
            state <= IDLE;
            src_f <= '0;
            snk_f <= '0;
            eng_f <= 1'b0;
            cnt_out_o <= '0;
            iter_o <= '0;
         end else begin
            case (state)
               IDLE: if (trigger_i) begin
                  nb_iter_q <= nb_iter_i;
                  limit_q <= cnt_limit_i;
                  iter_o <= '0;
                  state <= nb_iter_i == '0 ? FINISHED : START;
               end
               START: begin
                  cnt_out_o <= '0;
                  src_f <= '0;
                  snk_f <= '0;
                  eng_f <= 1'b0;
                  if (&src_ready_i && &snk_ready_i) begin
                     src_req_start_o <= '1;
                     snk_req_start_o <= '1;
                     eng_start_o <= 1'b1;
                     state <= COMPUTE;
                  end
               end
               COMPUTE: begin
                  src_f <= src_f | src_done_i;
                  snk_f <= snk_f | snk_done_i;
                  eng_f <= eng_f | eng_done_i;
                  for (int k = 0; k < N_OUT; k++)
                     if (out_hs_i[k] && cnt_out_o[k*CNT_W +: CNT_W] != limit_q)
                        cnt_out_o[k*CNT_W +: CNT_W] <= cnt_out_o[k*CNT_W +: CNT_W] + CNT_W'(1);
                  if (at_lim && (eng_f || eng_done_i)) state <= WAIT_STRM;
               end
               WAIT_STRM: begin
                  src_f <= src_f | src_done_i;
                  snk_f <= snk_f | snk_done_i;
                  if (&(src_f | src_done_i) && &(snk_f | snk_done_i)) state <= UPDATE;
               end
               UPDATE: begin
                  iter_o <= iter_o + 16'd1;
                  state <= (iter_o + 16'd1 == nb_iter_q) ? FINISHED : START;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
